// File: rtl/irpr_pkg.sv
// Shared definitions for the IRPR parallel port controllers: CSR bit map,
// receive FSM states and the vectored-interrupt handshake states.
package irpr_pkg;

    localparam int CSR_OVR  = 15;
    localparam int CSR_FULL = 8;
    localparam int CSR_DONE = 7;
    localparam int CSR_IE   = 6;
    localparam int CSR_ENA  = 0;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_STB  = 2'd1,
        R_ACK  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        i_idle = 2'd0,
        i_req  = 2'd1,
        i_wait = 2'd2
    } irq_state_t;

    // Filter window: the level may only change when every sample agrees.
    function automatic logic all_agree(input logic [3:0] samples);
        return (samples == 4'hF) || (samples == 4'h0);
    endfunction

endpackage

// File: rtl/irpr_rx_fifo.sv
// Receive byte buffer. With IRPR_RX_FIFO_EN defined it is a 2^FIFO_AW-entry
// circular FIFO; otherwise a single holding register (full == non-empty).
module irpr_rx_fifo
    import irpr_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [7:0]         din,
    output logic [7:0]         head,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    logic wr_en;
    logic rd_en;

    assign rd_en = pop & ~empty;
    // A push into a full buffer is only legal when the same clock frees a slot.
    assign wr_en = push & (~full | rd_en);

`ifdef IRPR_RX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= din;
    end

    assign head  = mem[rptr];
    assign full  = (count == (FIFO_AW+1)'(DEPTH));
    assign empty = (count == '0);
`else
    logic       valid;
    logic [7:0] hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
        end else if (rd_en) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) hold <= din;
    end

    assign head  = hold;
    assign count = {{FIFO_AW{1'b0}}, valid};
    assign full  = valid;
    assign empty = ~valid;
`endif

endmodule

// File: rtl/irpr_rx.sv
// IRPR parallel input port on the Wishbone bus: conditioned strobe/init inputs,
// BUSY/ACK handshake, CSR/DAT registers and vectored interrupt. Buffer depth
// is selected by IRPR_RX_FIFO_EN (undefined: single holding register).
module irpr_rx
    import irpr_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int ACK_CYC = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        iack,
    input  logic [7:0]  rp_data,
    input  logic        rp_stb_n,
    input  logic        rp_init_n,
    output logic        rp_busy,
    output logic        rp_ack_n,
    output logic        rp_err_n
);

    localparam logic [7:0] ACK_LAST = 8'(ACK_CYC - 1);

    logic       stb_p0, stb_p1, init_p0, init_p1;
    logic [7:0] data_p0, data_p1;
    logic [2:0] stb_hist, init_hist;
    logic       stb_filt, stb_filt_q, init_filt;
    logic       stb_fall, stb_high, init_act;

    logic       acc, csr_wr, csr_rd, dat_rd;
    logic       ie, ena, ovr, trig;
    logic       push, pop, ovr_set, trig_set, trig_clr;
    logic [15:0] csr_val, rd_data;

    logic [7:0]       fifo_head;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_full, fifo_empty;

    rx_state_t  rx_state, rx_next;
    logic [7:0] ack_cnt;
    irq_state_t irq_state, irq_next;
    logic       irq_d;

    // Stage p0/p1: two-flop synchronizers, then the 4-sample agreement filter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            stb_p0     <= 1'b1;
            stb_p1     <= 1'b1;
            init_p0    <= 1'b1;
            init_p1    <= 1'b1;
            stb_hist   <= 3'b111;
            init_hist  <= 3'b111;
            stb_filt   <= 1'b1;
            stb_filt_q <= 1'b1;
            init_filt  <= 1'b1;
        end else begin
            stb_p0     <= rp_stb_n;
            stb_p1     <= stb_p0;
            init_p0    <= rp_init_n;
            init_p1    <= init_p0;
            stb_hist   <= {stb_hist[1:0], stb_p1};
            init_hist  <= {init_hist[1:0], init_p1};
            if (all_agree({stb_hist, stb_p1}))   stb_filt  <= stb_p1;
            if (all_agree({init_hist, init_p1})) init_filt <= init_p1;
            stb_filt_q <= stb_filt;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        data_p0 <= rp_data;
        data_p1 <= data_p0;
    end

    // The handshake acts one clock after the filter recognizes an edge.
    assign stb_fall = stb_filt_q & ~stb_filt;
    assign stb_high = stb_filt_q & stb_filt;
    assign init_act = ~init_filt;

    assign acc    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign csr_wr = acc &  wb_we_i & ~wb_adr_i[1];
    assign csr_rd = acc & ~wb_we_i & ~wb_adr_i[1];
    assign dat_rd = acc & ~wb_we_i &  wb_adr_i[1];
    assign pop    = dat_rd & ~fifo_empty;

    irpr_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .pop   (pop),
        .flush (init_act),
        .din   (data_p1),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rp_busy  = (rx_state != R_IDLE) | ~ena | fifo_full | init_act;
    assign rp_ack_n = (rx_state != R_ACK);
    assign rp_err_n = ena;

    always_comb begin
        rx_next = rx_state;
        push    = 1'b0;
        ovr_set = 1'b0;
        if (init_act) begin
            rx_next = R_IDLE;
        end else begin
            if (stb_fall && rp_busy) ovr_set = 1'b1;
            case (rx_state)
                R_IDLE: if (stb_fall && !rp_busy) begin
                    push    = 1'b1;
                    rx_next = R_STB;
                end
                R_STB:  if (stb_high) rx_next = R_ACK;
                R_ACK:  if (ack_cnt == ACK_LAST) rx_next = R_IDLE;
                default: rx_next = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_state <= R_IDLE;
            ack_cnt  <= '0;
        end else begin
            rx_state <= rx_next;
            ack_cnt  <= (rx_state == R_ACK) ? ack_cnt + 1'b1 : 8'd0;
        end
    end

    // A push only raises the trigger when it makes the buffer non-empty.
    assign trig_set = ovr_set | (push & fifo_empty);

    always_comb begin
        irq_next = irq_state;
        irq_d    = irq;
        trig_clr = 1'b0;
        case (irq_state)
            i_idle: if (ie && trig) begin
                irq_d    = 1'b1;
                irq_next = i_req;
            end
            i_req: if (!ie) begin
                irq_next = i_idle;
            end else if (iack) begin
                irq_d    = 1'b0;
                trig_clr = 1'b1;
                irq_next = i_wait;
            end
            i_wait: if (!iack) irq_next = i_idle;
            default: irq_next = i_idle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_state <= i_idle;
            irq       <= 1'b0;
            trig      <= 1'b0;
        end else begin
            irq_state <= irq_next;
            irq       <= irq_d;
            if (trig_set)      trig <= 1'b1;
            else if (trig_clr) trig <= 1'b0;
        end
    end

    always_comb begin
        csr_val           = '0;
        csr_val[CSR_OVR]  = ovr;
        csr_val[CSR_FULL] = fifo_full;
        csr_val[CSR_DONE] = ~fifo_empty;
        csr_val[CSR_IE]   = ie;
        csr_val[CSR_ENA]  = ena;
    end

    assign rd_data = wb_adr_i[1] ? (fifo_empty ? 16'h0000 : {8'h00, fifo_head}) : csr_val;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ie       <= 1'b0;
            ena      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= (acc && !wb_we_i) ? rd_data : 16'h0000;
            if (csr_wr) begin
                ie  <= wb_dat_i[CSR_IE];
                ena <= wb_dat_i[CSR_ENA];
            end
            // A new overrun outranks the clear from a coincident CSR read.
            if (init_act)     ovr <= 1'b0;
            else if (ovr_set) ovr <= 1'b1;
            else if (csr_rd)  ovr <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[0], wb_dat_i[15:7], wb_dat_i[5:1], fifo_count};

endmodule

// File: tb/tb_irpr_rx.sv
// Self-checking bench for irpr_rx: register vector table, handshake timing
// sequences, and a randomized run against a queue-based behavioural model.
module tb_irpr_rx;

    localparam int FIFO_AW = 4;
    localparam int ACK_CYC = 8;
`ifdef IRPR_RX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  adr = '0;
    logic [15:0] dat_w = '0;
    logic [15:0] dat_r;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic        ack;
    logic        irq;
    logic        iack = 1'b0;
    logic [7:0]  rp_data = '0;
    logic        rp_stb_n = 1'b1;
    logic        rp_init_n = 1'b1;
    logic        rp_busy, rp_ack_n, rp_err_n;

    int total = 0;
    int bad = 0;

    logic [7:0] mq[$];
    logic       m_ena = 1'b0, m_ie = 1'b0, m_ovr = 1'b0;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[11];

    irpr_rx #(.FIFO_AW(FIFO_AW), .ACK_CYC(ACK_CYC)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_ack_o (ack),
        .irq      (irq),
        .iack     (iack),
        .rp_data  (rp_data),
        .rp_stb_n (rp_stb_n),
        .rp_init_n(rp_init_n),
        .rp_busy  (rp_busy),
        .rp_ack_n (rp_ack_n),
        .rp_err_n (rp_err_n)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] csr_model();
        return {m_ovr, 6'b0, (mq.size() == DEPTH), (mq.size() != 0), m_ie, 5'b0, m_ena};
    endfunction

    task automatic bus(input logic w, input logic [1:0] a, input logic [15:0] wd,
                       output logic [15:0] rd);
        logic got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = wd;
        rd = '0;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                rd = dat_r;
                got = 1'b1;
            end
        end
        if (!got) chk("bus_ack_timeout", 0, 1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic csr_write(input logic [15:0] v);
        logic [15:0] d;
        bus(1'b1, 2'b00, v, d);
        m_ena = v[0];
        m_ie  = v[6];
    endtask

    task automatic csr_check(input string name);
        logic [15:0] d;
        logic [15:0] e;
        e = csr_model();
        bus(1'b0, 2'b00, 16'h0, d);
        chk(name, d, e);
        m_ovr = 1'b0;
    endtask

    task automatic dat_check(input string name);
        logic [15:0] d;
        logic [15:0] e;
        e = 16'h0000;
        if (mq.size() != 0) e = {8'h00, mq.pop_front()};
        bus(1'b0, 2'b10, 16'h0, d);
        chk(name, d, e);
    endtask

    task automatic send(input logic [7:0] b, input int low, output logic seen);
        logic done;
        @(negedge clk);
        rp_data = b;
        rp_stb_n = 1'b0;
        repeat (low) @(negedge clk);
        rp_stb_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (!rp_ack_n) seen = 1'b1;
        end
        if (seen) begin
            done = 1'b0;
            for (int i = 0; i < ACK_CYC + 20 && !done; i++) begin
                @(posedge clk); #1;
                if (rp_ack_n) done = 1'b1;
            end
            if (!done) chk("ack_release_timeout", 0, 1);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic init_pulse();
        @(negedge clk);
        rp_init_n = 1'b0;
        repeat (10) @(negedge clk);
        rp_init_n = 1'b1;
        repeat (10) @(negedge clk);
        mq.delete();
        m_ovr = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic        seen;
        int          n;
        int          nb;
        logic [15:0] wd;
        logic [7:0]  b;

        vecs[0]  = '{1'b1, 2'b00, 16'h0041, 16'h0000};
        vecs[1]  = '{1'b0, 2'b00, 16'h0000, 16'h0041};
        vecs[2]  = '{1'b1, 2'b00, 16'hFFFF, 16'h0000};
        vecs[3]  = '{1'b0, 2'b00, 16'h0000, 16'h0041};
        vecs[4]  = '{1'b1, 2'b00, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 2'b01, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b0, 2'b10, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b1, 2'b10, 16'h1234, 16'h0000};
        vecs[8]  = '{1'b0, 2'b11, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b1, 2'b01, 16'h0041, 16'h0000};
        vecs[10] = '{1'b0, 2'b00, 16'h0000, 16'h0041};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_r, 16'h0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", rp_busy, 1);
        chk("rst_ack_n", rp_ack_n, 1);
        chk("rst_err_n", rp_err_n, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].wd, d);
            if (!vecs[i].we) chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        m_ena = 1'b1; m_ie = 1'b1;
        chk("enable_err_n", rp_err_n, 1);
        chk("enable_busy", rp_busy, 0);

        // Single byte: busy/ack timing, interrupt handshake, readback
        @(negedge clk);
        rp_data = 8'h5A;
        rp_stb_n = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rp_busy && n < 20);
        chk("busy_latency", n, 7);
        repeat (10 - n) @(posedge clk);
        @(negedge clk);
        rp_stb_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rp_ack_n && n < 20);
        chk("ack_latency", n, 8);
        n = 0;
        while (!rp_ack_n && n < 300) begin
            n++;
            @(posedge clk); #1;
        end
        chk("ack_width", n, ACK_CYC);
        mq.push_back(8'h5A);
        csr_check("csr_done");
        chk("irq_set", irq, 1);
        @(negedge clk);
        iack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("irq_iack", irq, 0);
        @(negedge clk);
        iack = 1'b0;
        dat_check("dat_5a");
        csr_check("csr_after_pop");

        // Fill the buffer, overrun, drain in order
        csr_write(16'h0001);
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'(8'h10 + i * 13);
            send(b, 10, seen);
            chk("fill_ack", seen, 1);
            mq.push_back(b);
        end
        chk("full_busy", rp_busy, 1);
        csr_check("csr_full");
        send(8'hEE, 10, seen);
        chk("ovr_noack", seen, 0);
        m_ovr = 1'b1;
        csr_check("csr_ovr");
        for (int i = 0; i < DEPTH; i++) dat_check("drain");
        csr_check("csr_ovr_clr");

        // Init flush with bytes buffered
        csr_write(16'h0041);
        nb = (DEPTH < 3) ? DEPTH : 3;
        for (int i = 0; i < nb; i++) begin
            b = 8'(8'hA0 + i);
            send(b, 10, seen);
            chk("init_fill_ack", seen, 1);
            mq.push_back(b);
        end
        @(negedge clk);
        iack = 1'b1;
        repeat (3) @(negedge clk);
        iack = 1'b0;
        init_pulse();
        csr_check("csr_after_init");
        dat_check("dat_after_init");

        // Glitch rejection
        send(8'h33, 3, seen);
        chk("glitch_noack", seen, 0);
        chk("glitch_busy", rp_busy, 0);
        csr_check("csr_after_glitch");

        // Randomized run against the model
        csr_write(16'h0001);
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    b = 8'($urandom);
                    n = (m_ena && mq.size() < DEPTH) ? 1 : 0;
                    send(b, 8 + $urandom_range(0, 4), seen);
                    chk("rnd_ack", seen, n);
                    if (n == 1) mq.push_back(b);
                    else m_ovr = 1'b1;
                end
                4, 5: dat_check("rnd_dat");
                6:    csr_check("rnd_csr");
                7: begin
                    wd = 16'($urandom);
                    wd[0] = ($urandom_range(0, 3) != 0);
                    csr_write(wd);
                end
                8: init_pulse();
                default: chk("rnd_busy", rp_busy, (m_ena && mq.size() < DEPTH) ? 0 : 1);
            endcase
        end

        // Reset in the middle of the ACK pulse
        init_pulse();
        csr_write(16'h0041);
        @(negedge clk);
        rp_data = 8'h77;
        rp_stb_n = 1'b0;
        repeat (10) @(negedge clk);
        rp_stb_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rp_ack_n && n < 30);
        chk("rst_test_ack_low", rp_ack_n, 0);
        chk("rst_test_irq_high", irq, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ack_n", rp_ack_n, 1);
        chk("midrst_busy", rp_busy, 1);
        chk("midrst_irq", irq, 0);
        chk("midrst_err_n", rp_err_n, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_ovr = 1'b0; m_ena = 1'b0; m_ie = 1'b0;
        csr_check("csr_after_midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
